// File: rtl/demux_reg8_wr_pkg.sv
// Shared sizes and types for the 8-entry register write path.
package demux_reg8_pkg;
  localparam int NREGS = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [NREGS-1:0] onehot_t;
endpackage

// File: rtl/demux_reg8_wr_if.sv
// Write request channel: valid/ready handshake carrying a destination index and data.
interface demux_reg8_wr_if
  import demux_reg8_pkg::*;
#(
  parameter int WIDTH = 64
);
  logic             wr_valid;
  logic             wr_ready;
  sel_t             wr_sel;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/demux_reg8_wr_dec3to8.sv
// 3-to-8 one-hot decoder, the write-side mirror of the 8:1 read select.
module dec3to8
  import demux_reg8_pkg::*;
(
  input  sel_t    sel,
  input  logic    en,
  output onehot_t onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/demux_reg8_wr.sv
// Two-stage write demux: decode captures the request, commit loads one of eight registers.
module demux_reg8_wr
  import demux_reg8_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int ZERO_REG0 = 1
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   freeze,
  demux_reg8_wr_if.slave         wr,
  output logic                   pend_valid,
  output sel_t                   pend_sel,
  output onehot_t                commit_onehot,
  output logic [7:0]             commit_cnt,
  output logic [NREGS*WIDTH-1:0] regs_flat
);
  localparam onehot_t WMASK = (ZERO_REG0 != 0) ? onehot_t'(8'hFE) : onehot_t'(8'hFF);

  logic             vld_p0_q;
  sel_t             sel_p0_q;
  onehot_t          oh_p0_q;
  logic [WIDTH-1:0] data_p0_q;
  onehot_t          oh_p0_d;

  logic [WIDTH-1:0] regs_q [NREGS];
  onehot_t          commit_oh_p1_q;
  logic [7:0]       cnt_q;

  logic    accept;
  logic    commit;
  onehot_t eff_oh;

  assign wr.wr_ready = reset_n && !clr && (!vld_p0_q || !freeze);
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign commit      = vld_p0_q && !freeze;
  // Writes to a hardwired-zero register are masked out here, so they neither load nor count.
  assign eff_oh      = oh_p0_q & WMASK;

  dec3to8 u_dec (
    .sel    (wr.wr_sel),
    .en     (wr.wr_valid),
    .onehot (oh_p0_d)
  );

  // Decode stage boundary
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p0_q <= 1'b0;
      sel_p0_q <= '0;
      oh_p0_q  <= '0;
    end else if (clr) begin
      vld_p0_q <= 1'b0;
      sel_p0_q <= '0;
      oh_p0_q  <= '0;
    end else if (accept) begin
      vld_p0_q <= 1'b1;
      sel_p0_q <= wr.wr_sel;
      oh_p0_q  <= oh_p0_d;
    end else if (commit) begin
      vld_p0_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) data_p0_q <= wr.wr_data;
  end

  // Commit stage boundary
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      commit_oh_p1_q <= '0;
      cnt_q          <= '0;
    end else if (clr) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      commit_oh_p1_q <= '0;
    end else begin
      commit_oh_p1_q <= commit ? eff_oh : '0;
      if (commit && (eff_oh != '0)) begin
        cnt_q <= cnt_q + 8'd1;
        for (int i = 0; i < NREGS; i++) begin
          if (eff_oh[i]) regs_q[i] <= data_p0_q;
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
  end

  assign pend_valid    = vld_p0_q;
  assign pend_sel      = sel_p0_q;
  assign commit_onehot = commit_oh_p1_q;
  assign commit_cnt    = cnt_q;
endmodule

// File: tb/tb_demux_reg8_wr.sv
// Directed bench for demux_reg8_wr: reset, sweep, freeze, same-index, clr and mid-stream reset.
module tb_demux_reg8_wr;
  import demux_reg8_pkg::*;

  localparam int WIDTH = 64;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   clr;
  logic                   freeze;
  logic                   pend_valid;
  sel_t                   pend_sel;
  onehot_t                commit_onehot;
  logic [7:0]             commit_cnt;
  logic [NREGS*WIDTH-1:0] regs_flat;

  int nerr = 0;
  int nchk = 0;

  demux_reg8_wr_if #(.WIDTH(WIDTH)) wif ();

  demux_reg8_wr #(.WIDTH(WIDTH), .ZERO_REG0(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clr           (clr),
    .freeze        (freeze),
    .wr            (wif),
    .pend_valid    (pend_valid),
    .pend_sel      (pend_sel),
    .commit_onehot (commit_onehot),
    .commit_cnt    (commit_cnt),
    .regs_flat     (regs_flat)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rg(input int i);
    return regs_flat[i*WIDTH +: WIDTH];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NREGS; i++) chk($sformatf("%s_reg%0d", tag, i), rg(i), 64'h0);
  endtask

  initial begin
    reset_n      = 1'b0;
    clr          = 1'b0;
    freeze       = 1'b0;
    wif.wr_valid = 1'b0;
    wif.wr_sel   = '0;
    wif.wr_data  = '0;

    // Reset
    step();
    reset_n = 1'b1;
    #1;
    chk_all_zero("rst");
    chk("rst_ready", 64'(wif.wr_ready), 64'h1);
    chk("rst_pend", 64'(pend_valid), 64'h0);
    chk("rst_cnt", 64'(commit_cnt), 64'h0);
    chk("rst_oh", 64'(commit_onehot), 64'h0);

    // Sweep sel 0..7 at one write per cycle
    wif.wr_valid = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      wif.wr_sel  = sel_t'(k);
      wif.wr_data = 64'(16 + k);
      step();
      chk($sformatf("sweep_pend%0d", k), 64'(pend_sel), 64'(k));
      if (k == 1) chk("sweep_oh0", 64'(commit_onehot), 64'h00);
      if (k >= 2) chk($sformatf("sweep_oh%0d", k - 1), 64'(commit_onehot), 64'(1 << (k - 1)));
    end
    wif.wr_valid = 1'b0;
    step();
    chk("sweep_oh7", 64'(commit_onehot), 64'h80);
    chk("sweep_pend_clr", 64'(pend_valid), 64'h0);
    chk("sweep_reg0", rg(0), 64'h0);
    for (int i = 1; i < NREGS; i++) chk($sformatf("sweep_reg%0d", i), rg(i), 64'(16 + i));
    chk("sweep_cnt", 64'(commit_cnt), 64'd7);

    // Freeze holds a pending write
    wif.wr_valid = 1'b1;
    wif.wr_sel   = 3'd5;
    wif.wr_data  = 64'hAA;
    step();
    wif.wr_valid = 1'b0;
    freeze       = 1'b1;
    #1;
    chk("frz_ready", 64'(wif.wr_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("frz_pend_c%0d", c), 64'(pend_valid), 64'h1);
      chk($sformatf("frz_sel_c%0d", c), 64'(pend_sel), 64'd5);
      chk($sformatf("frz_reg5_c%0d", c), rg(5), 64'h15);
      chk($sformatf("frz_oh_c%0d", c), 64'(commit_onehot), 64'h0);
      chk($sformatf("frz_rdy_c%0d", c), 64'(wif.wr_ready), 64'h0);
    end
    freeze = 1'b0;
    step();
    chk("frz_rel_reg5", rg(5), 64'hAA);
    chk("frz_rel_oh", 64'(commit_onehot), 64'h20);
    chk("frz_rel_cnt", 64'(commit_cnt), 64'd8);
    chk("frz_rel_pend", 64'(pend_valid), 64'h0);

    // Back-to-back writes to one index
    wif.wr_valid = 1'b1;
    wif.wr_sel   = 3'd3;
    wif.wr_data  = 64'h1;
    step();
    wif.wr_data = 64'h2;
    step();
    chk("b2b_first", rg(3), 64'h1);
    wif.wr_valid = 1'b0;
    step();
    chk("b2b_last", rg(3), 64'h2);
    chk("b2b_oh", 64'(commit_onehot), 64'h08);
    chk("b2b_cnt", 64'(commit_cnt), 64'd10);

    // clr while a write is pending
    wif.wr_valid = 1'b1;
    wif.wr_sel   = 3'd4;
    wif.wr_data  = 64'h44;
    step();
    wif.wr_valid = 1'b0;
    chk("clr_pre_pend", 64'(pend_valid), 64'h1);
    chk("clr_pre_sel", 64'(pend_sel), 64'd4);
    clr = 1'b1;
    #1;
    chk("clr_ready", 64'(wif.wr_ready), 64'h0);
    step();
    clr = 1'b0;
    chk("clr_pend", 64'(pend_valid), 64'h0);
    chk("clr_oh", 64'(commit_onehot), 64'h0);
    chk("clr_cnt", 64'(commit_cnt), 64'd10);
    chk_all_zero("clr");
    step();
    chk("clr_after_reg4", rg(4), 64'h0);
    chk("clr_after_oh", 64'(commit_onehot), 64'h0);

    // Reset mid-stream discards the pending write
    wif.wr_valid = 1'b1;
    wif.wr_sel   = 3'd6;
    wif.wr_data  = 64'h66;
    step();
    wif.wr_sel  = 3'd2;
    wif.wr_data = 64'h22;
    step();
    wif.wr_valid = 1'b0;
    chk("mrst_pre_reg6", rg(6), 64'h66);
    chk("mrst_pre_cnt", 64'(commit_cnt), 64'd11);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("mrst_pend", 64'(pend_valid), 64'h0);
    chk("mrst_sel", 64'(pend_sel), 64'h0);
    chk("mrst_oh", 64'(commit_onehot), 64'h0);
    chk("mrst_cnt", 64'(commit_cnt), 64'h0);
    chk("mrst_ready", 64'(wif.wr_ready), 64'h1);
    chk_all_zero("mrst");
    step();
    chk("mrst_after_reg2", rg(2), 64'h0);
    chk("mrst_after_oh", 64'(commit_onehot), 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
